// File: rtl/mlp_train_sequencer_pkg.sv
// rtl/mlp_train_sequencer_pkg.sv - shared types and loss helper for the MLP training sequencer
package mlp_train_sequencer_pkg;

    localparam real EPSILON = 1.0e-7;

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        UPDATE,
        EPOCH_END,
        DONE
    } train_state_e;

    // Binary cross-entropy for one target; EPSILON keeps ln() finite at p=0 or p=1.
    function automatic real bce_loss(input real y, input real p);
        return -(y * $ln(p + EPSILON) + (1.0 - y) * $ln(1.0 - p + EPSILON));
    endfunction

endpackage

// File: rtl/mlp_sample_store.sv
// rtl/mlp_sample_store.sv - small sample store with append write, clear and asynchronous indexed read
module mlp_sample_store #(
    parameter int INPUTS  = 2,
    parameter int OUTPUTS = 1,
    parameter int DEPTH   = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  real           wr_values   [INPUTS],
    input  real           wr_expected [OUTPUTS],
    input  logic          clear,
    input  logic [AW-1:0] rd_idx,
    output real           rd_values   [INPUTS],
    output real           rd_expected [OUTPUTS],
    output logic [CW-1:0] count
);

    real  mem_values   [DEPTH][INPUTS];
    real  mem_expected [DEPTH][OUTPUTS];
    logic wr_ok;

    assign wr_ok = wr_en && !clear && (count < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_ok) begin
            count <= count + CW'(1);
        end
    end

    // Contents are not reset; only entries below count are ever read by the sequencer.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < INPUTS; i++) mem_values[count[AW-1:0]][i] <= wr_values[i];
            for (int o = 0; o < OUTPUTS; o++) mem_expected[count[AW-1:0]][o] <= wr_expected[o];
        end
    end

    always_comb begin
        for (int i = 0; i < INPUTS; i++) rd_values[i] = mem_values[rd_idx][i];
        for (int o = 0; o < OUTPUTS; o++) rd_expected[o] = mem_expected[rd_idx][o];
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// rtl/mlp_train_sequencer.sv - replays the stored dataset into the MLP for N epochs, tracking BCE loss and LR decay
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int INPUTS  = 2,
    parameter int OUTPUTS = 1,
    parameter int DEPTH   = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  real           load_values   [INPUTS],
    input  real           load_expected [OUTPUTS],
    input  logic          clear,
    input  logic          start,
    input  logic [31:0]   num_epochs,
    input  real           lr_init,
    input  real           lr_decay,
    input  real           prediction    [OUTPUTS],
    output real           values        [INPUTS],
    output real           expected      [OUTPUTS],
    output logic          training,
    output real           learning_rate,
    output logic          busy,
    output logic          done,
    output real           epoch_loss,
    output logic          epoch_loss_valid,
    output logic [31:0]   epoch_count,
    output logic [CW-1:0] sample_count
);

    train_state_e  state, state_nxt;
    logic [AW-1:0] idx;
    logic [31:0]   epochs_q;
    real           lr_decay_q;
    real           loss_sum;
    real           sample_loss;
    real           rd_values   [INPUTS];
    real           rd_expected [OUTPUTS];
    real           values_q    [INPUTS];
    real           expected_q  [OUTPUTS];
    logic          presenting;
    logic          last_sample;
    logic          store_wr;
    logic          store_clear;

    assign presenting  = (state == PRESENT) || (state == UPDATE);
    assign last_sample = (CW'(idx) + CW'(1)) >= sample_count;
    assign load_ready  = (state == IDLE) && (sample_count < CW'(DEPTH));
    assign store_clear = (state == IDLE) && clear;
    assign store_wr    = load_valid && load_ready && !clear;
    assign busy        = (state != IDLE);

    mlp_sample_store #(
        .INPUTS  (INPUTS),
        .OUTPUTS (OUTPUTS),
        .DEPTH   (DEPTH)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (store_wr),
        .wr_values   (load_values),
        .wr_expected (load_expected),
        .clear       (store_clear),
        .rd_idx      (idx),
        .rd_values   (rd_values),
        .rd_expected (rd_expected),
        .count       (sample_count)
    );

    // Outside PRESENT/UPDATE the MLP keeps seeing the last sample it was given.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) values[i] = presenting ? rd_values[i] : values_q[i];
        for (int o = 0; o < OUTPUTS; o++) expected[o] = presenting ? rd_expected[o] : expected_q[o];
    end

    always_comb begin
        sample_loss = 0.0;
        for (int o = 0; o < OUTPUTS; o++) sample_loss = sample_loss + bce_loss(rd_expected[o], prediction[o]);
    end

    always_comb begin
        state_nxt        = state;
        training         = 1'b0;
        done             = 1'b0;
        epoch_loss_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ((sample_count == '0) || (num_epochs == '0)) ? DONE : PRESENT;
            end
            PRESENT: state_nxt = UPDATE;
            UPDATE: begin
                training  = 1'b1;
                state_nxt = last_sample ? EPOCH_END : PRESENT;
            end
            EPOCH_END: begin
                epoch_loss_valid = 1'b1;
                state_nxt        = ((epoch_count + 32'd1) == epochs_q) ? DONE : PRESENT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            epochs_q      <= '0;
            epoch_count   <= '0;
            lr_decay_q    <= 0.0;
            learning_rate <= 0.0;
            loss_sum      <= 0.0;
            epoch_loss    <= 0.0;
            for (int i = 0; i < INPUTS; i++) values_q[i] <= 0.0;
            for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= 0.0;
        end else begin
            state <= state_nxt;
            if (presenting) begin
                for (int i = 0; i < INPUTS; i++) values_q[i] <= rd_values[i];
                for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= rd_expected[o];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        epochs_q      <= num_epochs;
                        lr_decay_q    <= lr_decay;
                        learning_rate <= lr_init;
                        idx           <= '0;
                        epoch_count   <= '0;
                        loss_sum      <= 0.0;
                    end
                end
                PRESENT: loss_sum <= loss_sum + sample_loss;
                UPDATE: begin
                    if (!last_sample) idx <= idx + AW'(1);
                    else epoch_loss <= loss_sum / (real'(sample_count) * real'(OUTPUTS));
                end
                EPOCH_END: begin
                    epoch_count   <= epoch_count + 32'd1;
                    learning_rate <= learning_rate * lr_decay_q;
                    loss_sum      <= 0.0;
                    idx           <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// tb/tb_mlp_train_sequencer.sv - self-checking bench: load table, directed runs, randomized runs, mid-run reset
module tb_mlp_train_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    real         load_values [2];
    real         load_expected [1];
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_epochs = '0;
    real         lr_init = 0.0;
    real         lr_decay = 0.0;
    real         prediction [1];
    real         values [2];
    real         expected [1];
    logic        training;
    real         learning_rate;
    logic        busy;
    logic        done;
    real         epoch_loss;
    logic        epoch_loss_valid;
    logic [31:0] epoch_count;
    logic [2:0]  sample_count;

    int checks = 0;
    int errors = 0;
    int pred_mode = 0;

    real mv0 [DEPTH];
    real mv1 [DEPTH];
    real my  [DEPTH];
    int  mcount = 0;

    typedef struct {
        logic lv;
        logic clr;
        real  v0;
        real  v1;
        real  y;
        int   exp_count;
        logic exp_ready;
    } vec_t;

    vec_t tbl [7];

    mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_values      (load_values),
        .load_expected    (load_expected),
        .clear            (clear),
        .start            (start),
        .num_epochs       (num_epochs),
        .lr_init          (lr_init),
        .lr_decay         (lr_decay),
        .prediction       (prediction),
        .values           (values),
        .expected         (expected),
        .training         (training),
        .learning_rate    (learning_rate),
        .busy             (busy),
        .done             (done),
        .epoch_loss       (epoch_loss),
        .epoch_loss_valid (epoch_loss_valid),
        .epoch_count      (epoch_count),
        .sample_count     (sample_count)
    );

    always #5 clk = ~clk;

    function automatic real pfun(input int mode, input real a, input real b);
        return (mode != 0) ? (0.1 + 0.5 * a + 0.3 * b) : 0.5;
    endfunction

    always_comb prediction[0] = pfun(pred_mode, values[0], values[1]);

    function automatic real ref_bce(input real y, input real p);
        return -(y * $ln(p + 1.0e-7) + (1.0 - y) * $ln(1.0 - p + 1.0e-7));
    endfunction

    function automatic real absr(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic chk_i(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_r(input string name, input real got, input real want, input real tol);
        checks++;
        if (absr(got - want) > tol) begin
            errors++;
            $display("FAIL %s got %f want %f", name, got, want);
        end
    endtask

    task automatic do_load(input logic lv, input logic clr, input real v0, input real v1, input real y);
        load_valid = lv; clear = clr;
        load_values[0] = v0; load_values[1] = v1; load_expected[0] = y;
        @(posedge clk);
        if (clr) mcount = 0;
        else if (lv && mcount < DEPTH) begin
            mv0[mcount] = v0; mv1[mcount] = v1; my[mcount] = y; mcount++;
        end
        #1;
        load_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic run(input int ne, input real lr0, input real dec, input bit poke);
        int  n, per, exp_done, done_at, nvalid, trn_bad, e, pos, eff;
        bit  exp_trn;
        real sum;
        n = mcount;
        per = 2 * n + 1;
        eff = (n == 0 || ne == 0) ? 0 : ne;
        exp_done = (eff == 0) ? 1 : ne * per + 1;
        num_epochs = ne; lr_init = lr0; lr_decay = dec; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin clear = 1'b1; load_valid = 1'b1; end
        done_at = 0; nvalid = 0; trn_bad = 0;
        for (int k = 1; k <= exp_done + 5 && done_at == 0; k++) begin
            @(negedge clk);
            if (eff > 0 && k <= ne * per) begin
                e = (k - 1) / per;
                pos = (k - 1) % per;
                exp_trn = (pos < 2 * n) && (pos % 2 == 1);
                if (training !== exp_trn) trn_bad++;
                if (pos == 0) chk_r("epoch_lr", learning_rate, lr0 * (dec ** e), 1e-9);
                if (pos == 0 && e == 0) begin
                    chk_r("first_v0", values[0], mv0[0], 1e-12);
                    chk_r("first_v1", values[1], mv1[0], 1e-12);
                    chk_r("first_y", expected[0], my[0], 1e-12);
                end
                if (pos == 2 * n) begin
                    sum = 0.0;
                    for (int i = 0; i < n; i++) sum += ref_bce(my[i], pfun(pred_mode, mv0[i], mv1[i]));
                    chk_i("loss_valid_at_epoch_end", int'(epoch_loss_valid), 1);
                    chk_r("epoch_loss", epoch_loss, sum / n, 1e-6);
                end
            end
            if (epoch_loss_valid) nvalid++;
            if (done) done_at = k;
        end
        if (poke) begin clear = 1'b0; load_valid = 1'b0; end
        chk_i("done_cycle", done_at, exp_done);
        chk_i("epoch_count", int'(epoch_count), eff);
        chk_i("loss_valid_pulses", nvalid, eff);
        chk_i("training_pattern_errors", trn_bad, 0);
        chk_r("final_lr", learning_rate, lr0 * (dec ** eff), 1e-9);
        @(posedge clk); #1;
        chk_i("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        int n, ne, nodone;
        real lr0, dec;

        tbl[0] = '{1'b1, 1'b0, 0.0, 0.0, 0.0, 1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 0.0, 1.0, 1.0, 2, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1.0, 0.0, 1.0, 3, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1.0, 1.0, 0.0, 4, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 0.7, 0.7, 1.0, 4, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 0.3, 0.3, 1.0, 4, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 0.9, 0.9, 1.0, 4, 1'b0};
        load_values[0] = 0.0; load_values[1] = 0.0; load_expected[0] = 0.0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_r("rst_values0", values[0], 0.0, 0.0);
        chk_r("rst_values1", values[1], 0.0, 0.0);
        chk_r("rst_expected", expected[0], 0.0, 0.0);
        chk_r("rst_lr", learning_rate, 0.0, 0.0);
        chk_r("rst_loss", epoch_loss, 0.0, 0.0);
        chk_i("rst_flags", int'({training, busy, done, epoch_loss_valid}), 0);
        chk_i("rst_epoch_count", int'(epoch_count), 0);
        chk_i("rst_sample_count", int'(sample_count), 0);
        chk_i("rst_load_ready", int'(load_ready), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_load(tbl[i].lv, tbl[i].clr, tbl[i].v0, tbl[i].v1, tbl[i].y);
            @(negedge clk);
            chk_i($sformatf("tbl%0d_count", i), int'(sample_count), tbl[i].exp_count);
            chk_i($sformatf("tbl%0d_ready", i), int'(load_ready), int'(tbl[i].exp_ready));
        end

        pred_mode = 0;
        run(1, 0.5, 1.0, 1'b0);
        chk_r("xor_loss_const", epoch_loss, 0.693147, 1e-6);

        run(3, 0.8, 0.5, 1'b1);
        chk_i("busy_clear_ignored", int'(sample_count), 4);

        do_load(1'b1, 1'b1, 0.5, 0.5, 1.0);
        @(negedge clk);
        chk_i("clear_wins_count", int'(sample_count), 0);
        run(5, 0.5, 0.9, 1'b0);

        pred_mode = 1;
        for (int r = 0; r < 4; r++) begin
            do_load(1'b0, 1'b1, 0.0, 0.0, 0.0);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++)
                do_load(1'b1, 1'b0, $urandom_range(0, 1000) / 1000.0, $urandom_range(0, 1000) / 1000.0,
                        real'($urandom_range(0, 1)));
            ne  = $urandom_range(1, 3);
            lr0 = $urandom_range(1, 1000) / 1000.0;
            dec = $urandom_range(500, 1000) / 1000.0;
            run(ne, lr0, dec, 1'b0);
        end

        pred_mode = 0;
        do_load(1'b0, 1'b1, 0.0, 0.0, 0.0);
        do_load(1'b1, 1'b0, 0.0, 0.0, 0.0);
        do_load(1'b1, 1'b0, 0.0, 1.0, 1.0);
        do_load(1'b1, 1'b0, 1.0, 0.0, 1.0);
        do_load(1'b1, 1'b0, 1.0, 1.0, 0.0);
        num_epochs = 3; lr_init = 0.8; lr_decay = 0.5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk_i("pre_reset_epoch", int'(epoch_count), 1);
        #1 rst = 1'b0;
        #1;
        chk_i("mid_rst_flags", int'({training, busy, done, epoch_loss_valid}), 0);
        chk_i("mid_rst_sample_count", int'(sample_count), 0);
        chk_i("mid_rst_epoch_count", int'(epoch_count), 0);
        chk_i("mid_rst_load_ready", int'(load_ready), 1);
        chk_r("mid_rst_lr", learning_rate, 0.0, 0.0);
        chk_r("mid_rst_loss", epoch_loss, 0.0, 0.0);
        chk_r("mid_rst_values0", values[0], 0.0, 0.0);
        nodone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) nodone++;
        end
        chk_i("no_done_after_reset", nodone, 0);
        rst = 1'b1;
        mcount = 0;
        run(2, 0.5, 0.5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
